// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer.
// Optional subtract mode is enabled with SERIAL_ADD_SUB_EN.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE_C = 2'b00;
  localparam logic [1:0] ST_RUN_C  = 2'b01;
  localparam logic [1:0] ST_DONE_C = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_C,
    RUN  = ST_RUN_C,
    DONE = ST_DONE_C
  } state_t;

  function automatic logic maj3(
    input logic x,
    input logic y,
    input logic z
  );
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake bundle for serial_add_ctrl.
// Carries a `sub` request line when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout
  );
  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif

endinterface

// File: rtl/serial_add_ctrl_fa_bit_cell.sv
// Single-bit full adder cell, shared across all bit slots.
module fa_bit_cell
  import serial_add_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = maj3(i_a, i_b, i_ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell over WIDTH cycles.
// Define SERIAL_ADD_SUB_EN for a-b mode via the `sub` request line.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;
  logic [WIDTH-1:0] w_a_nxt;

`ifdef SERIAL_ADD_SUB_EN
  assign w_b_in = bus.sub ? ~bus.b : bus.b;
  assign w_c_in = bus.sub | bus.cin;
`else
  assign w_b_in = bus.b;
  assign w_c_in = bus.cin;
`endif

  assign w_accept = (r_state == IDLE) & bus.start;
  assign w_last   = (r_state == RUN) & (r_cnt == LAST);

  fa_bit_cell u_cell (
    .i_a  (r_a[0]),
    .i_b  (r_b[0]),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_co (w_co)
  );

  // A's shift register doubles as the result accumulator
  assign w_a_nxt = (r_a >> 1)
                 | (WIDTH'(w_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= w_b_in;
      r_carry <= w_c_in;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_a     <= w_a_nxt;
      r_b     <= r_b >> 1;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_a_nxt;
        r_cout <= w_co;
      end
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = (r_state == DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule
